// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer: frames the byte stream with VSYNC/HREF, packs RGB444 pixels
// and drives the frame-buffer write port. Optional macro CAPTURE_FRAME_SKIP_EN writes every other frame.
module cam_capture_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   input  logic              capture_en,
   output logic              bram_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(H_ACTIVE * V_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_ACTIVE} state_t;

   state_t            state_q, state_d;
   logic              vsync_q, vsync_d;
   logic              phase_q, phase_d;
   logic [3:0]        red_q, red_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]       wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic              bram_en_q, bram_en_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              skip_q, skip_d;
   logic              vs_rise, vs_fall;

`ifdef CAPTURE_FRAME_SKIP_EN
   logic              toggle_q, toggle_d;
`endif

   assign vs_rise = cam_vsync & ~vsync_q;
   assign vs_fall = ~cam_vsync & vsync_q;

   always_comb begin
      state_d   = state_q;
      vsync_d   = cam_vsync;
      phase_d   = phase_q;
      red_d     = red_q;
      cnt_d     = cnt_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      skip_d    = skip_q;
`ifdef CAPTURE_FRAME_SKIP_EN
      toggle_d  = toggle_q;
`endif

      // Address advances after each strobe but parks on the last pixel.
      if (wr_en_q && (wr_addr_q != LAST_ADDR))
         wr_addr_d = wr_addr_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            phase_d = 1'b0;
            if (vs_rise && capture_en)
               state_d = S_VSYNC;
         end
         S_VSYNC: begin
            if (vs_fall) begin
               wr_addr_d = '0;
               cnt_d     = '0;
               err_d     = 1'b0;
               phase_d   = 1'b0;
               state_d   = S_ACTIVE;
`ifdef CAPTURE_FRAME_SKIP_EN
               skip_d    = toggle_q;
               toggle_d  = ~toggle_q;
`else
               skip_d    = 1'b0;
`endif
            end
         end
         S_ACTIVE: begin
            if (cam_href) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  red_d = cam_data[3:0];
               end else if (cnt_q == TOTAL) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d     = cnt_q + 1'b1;
                  wr_en_d   = ~skip_q;
                  wr_data_d = {red_q, cam_data};
               end
            end else begin
               // A dangling first byte at line end means a short line.
               if (phase_q)
                  err_d = 1'b1;
               phase_d = 1'b0;
            end
            if (vs_rise) begin
               done_d  = ~skip_q;
               phase_d = 1'b0;
               if (cnt_d != TOTAL)
                  err_d = 1'b1;
               state_d = capture_en ? S_VSYNC : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_ACTIVE);
      bram_en_d = (busy_d && !skip_d) || wr_en_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         vsync_q   <= 1'b0;
         phase_q   <= 1'b0;
         red_q     <= '0;
         cnt_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         bram_en_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         skip_q    <= 1'b0;
`ifdef CAPTURE_FRAME_SKIP_EN
         toggle_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         vsync_q   <= vsync_d;
         phase_q   <= phase_d;
         red_q     <= red_d;
         cnt_q     <= cnt_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         bram_en_q <= bram_en_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         skip_q    <= skip_d;
`ifdef CAPTURE_FRAME_SKIP_EN
         toggle_q  <= toggle_d;
`endif
      end
   end

   assign bram_en    = bram_en_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl on a reduced 4x3 frame so whole frames fit in a short run.
module tb_cam_capture_ctrl;

   localparam int H  = 4;
   localparam int V  = 3;
   localparam int AW = 4;
   localparam int TOTAL = H * V;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cam_vsync = 1'b0;
   logic          cam_href = 1'b0;
   logic [7:0]    cam_data = 8'h00;
   logic          capture_en = 1'b0;
   logic          bram_en, wr_en, frame_done, frame_err, busy;
   logic [AW-1:0] wr_addr;
   logic [11:0]   wr_data;

   cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .capture_en(capture_en), .bram_en(bram_en), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_wr = 0, n_done = 0, n_bram = 0, bad_data = 0;
   int first_addr = -1, last_addr = -1, max_addr = 0;
   int err_at_done = -1, addr_at_done = -1;
   logic busy_prev = 1'b0;
   logic armed = 1'b0;
   int w0, d0, b0;

   // Output monitor, sampled mid-cycle while outputs are stable.
   always @(negedge clk) begin
      busy_prev <= busy;
      if (wr_en) begin
         n_wr <= n_wr + 1;
         if (armed) first_addr <= int'(wr_addr);
         armed <= 1'b0;
         last_addr <= int'(wr_addr);
         if (int'(wr_addr) > max_addr) max_addr <= int'(wr_addr);
         if (wr_data != 12'hABC) bad_data <= bad_data + 1;
      end else if (busy && !busy_prev) begin
         armed <= 1'b1;
      end
      if (frame_done) begin
         n_done <= n_done + 1;
         err_at_done <= int'(frame_err);
         addr_at_done <= int'(wr_addr);
      end
      if (bram_en && cam_href) n_bram <= n_bram + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic vs_pulse();
      cam_vsync = 1'b1;
      tick(3);
      cam_vsync = 1'b0;
      tick(3);
   endtask

   task automatic send_lines(input int n, input int odd_ln, input int cen_ln);
      for (int l = 0; l < n; l++) begin
         int nb;
         if (l == cen_ln) capture_en = 1'b0;
         nb = (l == odd_ln) ? 2 * H - 1 : 2 * H;
         for (int b = 0; b < nb; b++) begin
            cam_href = 1'b1;
            cam_data = b[0] ? 8'hBC : 8'hFA;
            tick(1);
         end
         cam_href = 1'b0;
         cam_data = 8'h00;
         tick(3);
      end
   endtask

   task automatic snap();
      tick(1);
      w0 = n_wr;
      d0 = n_done;
      b0 = n_bram;
   endtask

   initial begin
      tick(3);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_bram_en", int'(bram_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(frame_err), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_addr_data", int'({wr_addr, wr_data}), 0);
      rst_n = 1'b1;
      tick(2);
      capture_en = 1'b1;
`ifdef CAPTURE_FRAME_SKIP_EN
      vs_pulse();
      for (int f = 0; f < 4; f++) begin
         snap();
         send_lines(V, -1, -1);
         vs_pulse();
         check("skip_done", n_done - d0, (f % 2 == 0) ? 1 : 0);
         check("skip_writes", n_wr - w0, (f % 2 == 0) ? TOTAL : 0);
         check("skip_bram", n_bram - b0, (f % 2 == 0) ? 2 * TOTAL : 0);
      end
`else
      // Stream starts mid-frame: nothing may be written before a full VSYNC.
      snap();
      send_lines(V, -1, -1);
      check("mid_writes", n_wr - w0, 0);
      check("mid_busy", int'(busy), 0);
      vs_pulse();
      check("start_busy", int'(busy), 1);

      snap();
      send_lines(V, -1, -1);
      vs_pulse();
      check("clean_writes", n_wr - w0, TOTAL);
      check("clean_first", first_addr, 0);
      check("clean_last", last_addr, TOTAL - 1);
      check("clean_data", bad_data, 0);
      check("clean_done", n_done - d0, 1);
      check("clean_err", err_at_done, 0);

      snap();
      send_lines(V, 1, -1);
      vs_pulse();
      check("odd_writes", n_wr - w0, TOTAL - 1);
      check("odd_last", last_addr, TOTAL - 2);
      check("odd_err", err_at_done, 1);
      check("odd_done", n_done - d0, 1);
      snap();
      send_lines(V, -1, -1);
      vs_pulse();
      check("recover_err", err_at_done, 0);
      check("recover_writes", n_wr - w0, TOTAL);

      snap();
      send_lines(V + 1, -1, -1);
      vs_pulse();
      check("ovf_writes", n_wr - w0, TOTAL);
      check("ovf_addr_hold", addr_at_done, TOTAL - 1);
      check("ovf_max_addr", max_addr, TOTAL - 1);
      check("ovf_err", err_at_done, 1);
      check("ovf_done", n_done - d0, 1);

      snap();
      send_lines(V, -1, 1);
      vs_pulse();
      check("cen_writes", n_wr - w0, TOTAL);
      check("cen_done", n_done - d0, 1);
      check("cen_idle", int'(busy), 0);
      snap();
      send_lines(V, -1, -1);
      vs_pulse();
      check("off_writes", n_wr - w0, 0);
      check("off_done", n_done - d0, 0);

      capture_en = 1'b1;
      vs_pulse();
      snap();
      send_lines(V, -1, -1);
      vs_pulse();
      check("reen_writes", n_wr - w0, TOTAL);
      check("reen_err", err_at_done, 0);

      // Async reset in the middle of a line.
      for (int b = 0; b < 4; b++) begin
         cam_href = 1'b1;
         cam_data = b[0] ? 8'hBC : 8'hFA;
         tick(1);
      end
      rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_outs", int'({bram_en, wr_en, frame_err, frame_done, wr_addr}), 0);
      cam_href = 1'b0;
      tick(2);
      rst_n = 1'b1;
      snap();
      send_lines(V, -1, -1);
      check("arst_resync", n_wr - w0, 0);
      check("arst_idle", int'(busy), 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Write-side sequencer for the 640x480x12 frame buffer BRAM. Runs in the camera pixel-clock domain.
- Frames the OV7670 byte stream with VSYNC/HREF and packs byte pairs into RGB444 words.
- Drives the BRAM write port (bram_en, wr_en, wr_addr, data) with linear addresses 0..H_ACTIVE*V_ACTIVE-1.
- Reports frame completion and framing errors to the display side.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, frame buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  camera PCLK; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cam_vsync  in  1  camera VSYNC, active high during vertical blank
- cam_href  in  1  camera HREF, high while line bytes are valid
- cam_data  in  8  camera pixel byte
- capture_en  in  1  level enable; sampled only at frame boundaries
- bram_en  out  1  BRAM port enable
- wr_en  out  1  one-cycle write strobe per pixel
- wr_addr  out  ADDR_W  pixel write address
- wr_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_err  out  1  sticky framing error; cleared at start of each captured frame
- busy  out  1  high while in S_ACTIVE

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE; all outputs 0; byte phase=0; pixel count=0; vsync_d=0.
- vsync_d holds cam_vsync from the previous cycle. Rising edge = cam_vsync & ~vsync_d; falling edge = ~cam_vsync & vsync_d.
- S_IDLE:
  - Rising VSYNC edge with capture_en=1 -> S_VSYNC.
  - Never starts mid-frame, so the first partial frame after reset is discarded.
- S_VSYNC:
  - On falling VSYNC edge: wr_addr<=0, pixel count<=0, frame_err<=0, phase<=0 -> S_ACTIVE.
- S_ACTIVE (bram_en=1, busy=1):
  - While cam_href=1, phase toggles every cycle.
  - Phase 0 latches cam_data[3:0] as R.
  - Phase 1 registers wr_data<={R,cam_data}, pulses wr_en=1 next cycle, increments the pixel count.
  - Latency: wr_en/wr_data/wr_addr valid one cycle after the second byte is sampled.
  - wr_addr increments the cycle after each wr_en, so the first pixel of a frame writes address 0.
- HREF falls with phase=1 (odd byte count): dangling byte dropped, frame_err<=1, phase<=0.
- HREF low: phase held at 0, no writes.
- Overflow: pixel count already at H_ACTIVE*V_ACTIVE.
  - Further pixels are suppressed (wr_en stays 0) and wr_addr holds at the last value.
  - frame_err<=1.
- Rising VSYNC edge in S_ACTIVE ends the frame:
  - frame_done=1 for one cycle.
  - frame_err<=1 if pixel count != H_ACTIVE*V_ACTIVE.
  - Next state is S_VSYNC if capture_en=1, else S_IDLE.
- A pending write from the final byte pair still completes on the same cycle as the VSYNC edge (wr_en and frame_done may coincide).
- capture_en deasserted mid-frame: the current frame finishes normally, then S_IDLE.
- Async reset mid-frame: immediate return to S_IDLE with all outputs 0; resync on the next VSYNC.
- wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.

Optional Feature:
- Macro: CAPTURE_FRAME_SKIP_EN.
- Defined:
  - A 1-bit frame toggle flips on every S_VSYNC->S_ACTIVE transition (reset 0).
  - Frames entered with toggle=1 run through S_ACTIVE with bram_en=0 and wr_en=0, and frame_done is not pulsed; pixel counting and error checks still run.
  - Effective capture rate is halved, freeing BRAM bandwidth.
- Not defined: every frame is written; no toggle logic is present.

Test Plan:
- Reset then one full 640x480 frame, bytes 0x0A,0xBC per pixel -> 307200 wr_en pulses; first write addr 0, last addr 307199; wr_data=0xABC; frame_done=1 for one cycle; frame_err=0.
- Start stimulus mid-frame after reset (HREF active, no VSYNC) -> no wr_en until the first full VSYNC high-low sequence.
- Line with 1279 bytes -> last byte dropped; frame ends with 307199 writes; frame_err=1; next clean frame clears frame_err to 0.
- Frame with 481 lines -> writes stop at addr 307199, wr_addr holds, frame_err=1, frame_done pulses.
- capture_en dropped at line 100 -> frame completes with 307200 writes and frame_done; state returns to S_IDLE; no writes on the next frame.
- With CAPTURE_FRAME_SKIP_EN: 4 consecutive frames -> frame_done pulses on frames 1 and 3 only; 2x307200 total wr_en; bram_en=0 during frames 2 and 4.
